stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Front-end control stage for the stopwatch. It synchronises and debounces two raw
//  push-buttons (start/pause and clear) and turns each press into a single pulse.
//  A 3-state FSM then drives the 2-bit enable code consumed by the downstream seconds
//  counter: 00 = idle/cleared, 01 = count up, 10 = pause.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000  consecutive stable samples needed to accept a new level (>=2)
//  DB_W             19       debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  synchronous, active-high reset
//  btn_start  in   1  raw start/pause button, asynchronous, active-high
//  btn_clear  in   1  raw clear button, asynchronous, active-high
//  en         out  2  enable code to seconds counter: 00 IDLE, 01 RUN, 10 PAUSE (11 never driven)
//  clr        out  1  one-cycle pulse on the edge that enters IDLE via clear
//  running    out  1  1 while state == RUN
// BEHAVIOUR
//  Reset (synchronous; wins over all other activity in the same cycle):
//   - Clears both synchroniser flops, debounce counters, debounced levels and previous-level regs to 0.
//   - State goes to IDLE: en=00, clr=0, running=0.
//  Per button, identical logic:
//   - 2-flop synchroniser produces sync.
//   - Cycle with sync != db_level: counter += 1.
//   - Cycle with sync == db_level: counter cleared.
//   - Counter == DEBOUNCE_CYCLES-1 with mismatch still present: db_level toggles, counter clears.
//   - Both press and release therefore need DEBOUNCE_CYCLES stable samples.
//   - press = db_level & ~db_prev (db_prev = db_level delayed 1 cycle); one cycle wide.
//   - A held button gives exactly one press; there is no auto-repeat.
//  FSM (registered; en, running, clr all registered outputs):
//   - IDLE : start_p -> RUN;   clear_p ignored (stays IDLE, clr stays 0).
//   - RUN  : start_p -> PAUSE; clear_p ignored (a running watch cannot be cleared).
//   - PAUSE: clear_p -> IDLE with clr=1 for that one cycle; start_p -> RUN.
//   - Simultaneous start_p and clear_p: clear has priority where it is legal (PAUSE -> IDLE).
//     In IDLE and RUN the start action applies.
//   - clr returns to 0 on the following cycle.
//  Latency:
//   - Edge 1 = first rising edge that samples the raw button high (held stable afterwards).
//   - en changes on edge DEBOUNCE_CYCLES+3.
//   - Release is accepted DEBOUNCE_CYCLES+2 edges after the raw level falls.
//  Reset mid-debounce: partial counts are discarded and no press is generated afterwards
//   until a fresh DEBOUNCE_CYCLES stable high follows a debounced low.
//  Downstream contract: en is held constant between transitions; the seconds counter zeroes on 00.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Assert reset 3 cycles -> en=00, clr=0, running=0; stays so with buttons low for 20 cycles.
//  2. btn_start high 12 cycles from edge 1 -> en=01 and running=1 from edge 7, no further change.
//  3. btn_start high 3 cycles, then low; repeated 5 times (glitches) -> en stays 00 throughout.
//  4. RUN, release, press start -> en=10; press clear -> en=00 with clr=1 for exactly 1 cycle.
//  5. In RUN press clear -> en stays 01, clr never 1.
//     In PAUSE press start and clear together -> en=00, clr pulse.
//  6. Reset asserted during cycle 3 of a start press (raw still high) -> en=00.
//     No RUN until raw is released for >=4 cycles and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Front-end control stage for the stopwatch. Two raw push-buttons
//            (start/pause, clear) are each synchronised, debounced and turned
//            into a single-cycle press pulse. A 3-state FSM then produces the
//            2-bit enable code for the downstream seconds counter.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high reset
//            btn_start  - raw start/pause button (asynchronous, active-high)
//            btn_clear  - raw clear button (asynchronous, active-high)
//            en[1:0]    - 00 IDLE, 01 RUN, 10 PAUSE (11 never driven)
//            clr        - one-cycle pulse on the edge entering IDLE via clear
//            running    - 1 while the FSM is in RUN
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DB_W            = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [1:0] en,
    output logic       clr,
    output logic       running
);

    localparam int              c_NBTN    = 2;
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Bit 0 = start/pause, bit 1 = clear
    logic [c_NBTN-1:0] w_btn_raw;
    logic [c_NBTN-1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_start};

    // ------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge detector
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
        logic            r_meta_q;
        logic            r_sync_q;
        logic            r_level_q;
        logic            r_prev_q;
        logic [DB_W-1:0] r_cnt_q;
        logic            w_level_d;
        logic [DB_W-1:0] w_cnt_d;

        // Any sample agreeing with the current level restarts the count, so a
        // new level is only accepted after DEBOUNCE_CYCLES disagreeing samples
        // in a row. The count never exceeds DEBOUNCE_CYCLES-1.
        always_comb begin
            w_level_d = r_level_q;
            w_cnt_d   = '0;
            if (r_sync_q != r_level_q) begin
                if (r_cnt_q == c_DB_LAST) begin
                    w_level_d = ~r_level_q;
                end else begin
                    w_cnt_d = r_cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_meta_q  <= 1'b0;
                r_sync_q  <= 1'b0;
                r_level_q <= 1'b0;
                r_prev_q  <= 1'b0;
                r_cnt_q   <= '0;
            end else begin
                r_meta_q  <= w_btn_raw[gi];
                r_sync_q  <= r_meta_q;
                r_level_q <= w_level_d;
                r_prev_q  <= r_level_q;
                r_cnt_q   <= w_cnt_d;
            end
        end

        // High for exactly one cycle after the debounced level rises
        assign w_press[gi] = r_level_q & ~r_prev_q;
    end

    // ------------------------------------------------------------------------
    // Control FSM; all outputs registered
    // ------------------------------------------------------------------------
    logic   w_start_p;
    logic   w_clear_p;
    state_t r_state_q;
    state_t w_state_d;
    logic   r_clr_q;
    logic   w_clr_d;
    logic   r_running_q;
    logic   w_running_d;

    assign w_start_p = w_press[0];
    assign w_clear_p = w_press[1];

    always_comb begin
        w_state_d = r_state_q;
        w_clr_d   = 1'b0;
        case (r_state_q)
            // Clear is meaningless in IDLE and forbidden in RUN
            ST_IDLE: begin
                if (w_start_p) w_state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_start_p) w_state_d = ST_PAUSE;
            end
            // Clear wins over a simultaneous start
            ST_PAUSE: begin
                if (w_clear_p) begin
                    w_state_d = ST_IDLE;
                    w_clr_d   = 1'b1;
                end else if (w_start_p) begin
                    w_state_d = ST_RUN;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        w_running_d = (w_state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_clr_q     <= 1'b0;
            r_running_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_clr_q     <= w_clr_d;
            r_running_q <= w_running_d;
        end
    end

    // The state encoding is the enable code itself
    assign en      = r_state_q;
    assign clr     = r_clr_q;
    assign running = r_running_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Self-checking bench for stopwatch_ctrl (DEBOUNCE_CYCLES = 4).
//            A behavioural model predicts {en, clr, running} after every
//            rising edge into a queue; a monitor pops and compares on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int c_D = 4;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic [1:0] en;
    logic       clr;
    logic       running;

    int errors = 0;
    int checks = 0;

    // Expected {en[1:0], clr, running} per cycle
    logic [3:0] exp_q[$];

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(c_D),
        .DB_W           (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .en       (en),
        .clr      (clr),
        .running  (running)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. Each button keeps a window of raw samples; the two
    // newest are still in the synchroniser, and the debounced level flips once
    // the c_D samples before them all disagree with it. A press seen on one
    // edge drives the FSM on the following edge.
    // ------------------------------------------------------------------------
    initial begin : model
        bit         hist [2][c_D+2];
        bit         lvl  [2];
        bit         pend [2];
        bit         raw  [2];
        bit         all_diff;
        logic [1:0] st;
        bit         mclr;
        st   = 2'd0;
        mclr = 1'b0;
        for (int b = 0; b < 2; b++) begin
            lvl[b]  = 1'b0;
            pend[b] = 1'b0;
            for (int k = 0; k < c_D + 2; k++) hist[b][k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            raw[0] = btn_start;
            raw[1] = btn_clear;
            if (reset) begin
                st   = 2'd0;
                mclr = 1'b0;
                for (int b = 0; b < 2; b++) begin
                    lvl[b]  = 1'b0;
                    pend[b] = 1'b0;
                    for (int k = 0; k < c_D + 2; k++) hist[b][k] = 1'b0;
                end
            end else begin
                mclr = 1'b0;
                if (st == 2'd2 && pend[1]) begin
                    st   = 2'd0;
                    mclr = 1'b1;
                end else if (pend[0]) begin
                    st = (st == 2'd1) ? 2'd2 : 2'd1;
                end
                for (int b = 0; b < 2; b++) begin
                    for (int k = 0; k < c_D + 1; k++) hist[b][k] = hist[b][k+1];
                    hist[b][c_D+1] = raw[b];
                    all_diff = 1'b1;
                    for (int k = 0; k < c_D; k++)
                        if (hist[b][k] == lvl[b]) all_diff = 1'b0;
                    pend[b] = 1'b0;
                    if (all_diff) begin
                        lvl[b]  = ~lvl[b];
                        pend[b] = lvl[b];
                    end
                end
            end
            exp_q.push_back({st, mclr, (st == 2'd1)});
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: one comparison per cycle, away from the active edge
    // ------------------------------------------------------------------------
    initial begin : monitor
        logic [3:0] exp_v;
        logic [3:0] act_v;
        forever begin
            @(negedge clk);
            act_v = {en, clr, running};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty t=%0t actual en=%b clr=%b running=%b required a queued expectation",
                         $time, en, clr, running);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual en=%b clr=%b running=%b required en=%b clr=%b running=%b",
                             $time, act_v[3:2], act_v[1], act_v[0], exp_v[3:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    task automatic hold(input bit s, input bit c, input int n);
        btn_start = s;
        btn_clear = c;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        bit rs;
        bit rc;
        // Reset for 3 cycles, then idle with buttons low
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(0, 0, 20);

        // Short glitches must never be accepted
        repeat (5) begin
            hold(1, 0, 3);
            hold(0, 0, 3);
        end
        hold(0, 0, 6);

        // Long press: IDLE -> RUN
        hold(1, 0, 12);
        hold(0, 0, 10);

        // RUN -> PAUSE, then clear -> IDLE with clr pulse
        hold(1, 0, 8);
        hold(0, 0, 8);
        hold(0, 1, 8);
        hold(0, 0, 8);

        // Clear ignored in RUN; simultaneous press in PAUSE clears
        hold(1, 0, 8);
        hold(0, 0, 8);
        hold(0, 1, 8);
        hold(0, 0, 8);
        hold(1, 0, 8);
        hold(0, 0, 8);
        hold(1, 1, 8);
        hold(0, 0, 8);

        // Reset in the middle of a press, release, then a fresh press
        hold(1, 0, 2);
        reset = 1'b1;
        hold(1, 0, 1);
        reset = 1'b0;
        hold(1, 0, 1);
        hold(0, 0, 8);
        hold(1, 0, 8);
        hold(0, 0, 8);

        // Randomised activity with occasional reset
        repeat (300) begin
            rs    = 1'($urandom_range(0, 1));
            rc    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 49) == 0);
            if (reset) hold(rs, rc, 1);
            else       hold(rs, rc, $urandom_range(1, 10));
            reset = 1'b0;
        end
        hold(0, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
